// File: rtl/id_issue_ctrl_if.sv
// IF/ID/EX handshake, decoder feedback and WB retire bundle for id_issue_ctrl.
// The slave modport is the controller's view; the master modport is the view of its surroundings.
interface id_issue_ctrl_if;
    logic        if_valid_i;
    logic [31:0] if_inst_i;
    logic [31:0] if_pc_i;
    logic        id_allowin_o;
    logic        flush_i;
    logic [31:0] dec_inst_o;
    logic        dec_rj_use_i;
    logic        dec_rk_use_i;
    logic        dec_rd_use_i;
    logic        dec_we_i;
    logic [4:0]  dec_wdest_i;
    logic        ex_allowin_i;
    logic        id_to_ex_valid_o;
    logic [31:0] id_pc_o;
    logic        wb_valid_i;
    logic        wb_we_i;
    logic [4:0]  wb_dest_i;
    logic        stall_o;

    modport slave (
        input  if_valid_i, if_inst_i, if_pc_i, flush_i,
        input  dec_rj_use_i, dec_rk_use_i, dec_rd_use_i, dec_we_i, dec_wdest_i,
        input  ex_allowin_i, wb_valid_i, wb_we_i, wb_dest_i,
        output id_allowin_o, dec_inst_o, id_to_ex_valid_o, id_pc_o, stall_o
    );

    modport master (
        output if_valid_i, if_inst_i, if_pc_i, flush_i,
        output dec_rj_use_i, dec_rk_use_i, dec_rd_use_i, dec_we_i, dec_wdest_i,
        output ex_allowin_i, wb_valid_i, wb_we_i, wb_dest_i,
        input  id_allowin_o, dec_inst_o, id_to_ex_valid_o, id_pc_o, stall_o
    );
endinterface

// File: rtl/id_issue_ctrl.sv
// Decode-stage issue controller: holds the ID instruction, tracks pending GPR writes and stalls on RAW.
// Optional macro ID_WB_BYPASS_EN lets a source whose last pending write retires this cycle issue at once.
module id_issue_ctrl #(
    parameter int unsigned SB_CNT_W = 2
) (
    input logic           clk,
    input logic           rst_n,
    id_issue_ctrl_if.slave bus
);
    localparam logic [SB_CNT_W-1:0] SbMax = '1;
    localparam logic [SB_CNT_W-1:0] SbOne = SB_CNT_W'(1);

    logic                r_id_valid;
    logic [31:0]         r_inst;
    logic [31:0]         r_pc;
    logic [SB_CNT_W-1:0] r_sb [32];

    logic [SB_CNT_W-1:0] w_sb_d [32];
    logic [4:0]          w_rj;
    logic [4:0]          w_rk;
    logic [4:0]          w_rd;
    logic [31:0]         w_inc;
    logic [31:0]         w_dec;
    logic                w_rj_byp;
    logic                w_rk_byp;
    logic                w_rd_byp;
    logic                w_rj_hz;
    logic                w_rk_hz;
    logic                w_rd_hz;
    logic                w_hazard;
    logic                w_ready_go;
    logic                w_allowin;
    logic                w_issue;
    logic                w_load;
    logic                w_id_valid_d;

    assign w_rj = r_inst[9:5];
    assign w_rk = r_inst[14:10];
    assign w_rd = r_inst[4:0];

    // Per-register increment on issue and decrement on retire; r0 never counts.
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        if (w_issue && bus.dec_we_i) begin
            w_inc[bus.dec_wdest_i] = 1'b1;
        end
        if (bus.wb_valid_i && bus.wb_we_i) begin
            w_dec[bus.wb_dest_i] = 1'b1;
        end
        w_inc[0] = 1'b0;
        w_dec[0] = 1'b0;
    end

`ifdef ID_WB_BYPASS_EN
    // The last pending write retiring now is as good as done when the regfile writes first.
    assign w_rj_byp = w_dec[w_rj] && (r_sb[w_rj] == SbOne);
    assign w_rk_byp = w_dec[w_rk] && (r_sb[w_rk] == SbOne);
    assign w_rd_byp = w_dec[w_rd] && (r_sb[w_rd] == SbOne);
`else
    assign w_rj_byp = 1'b0;
    assign w_rk_byp = 1'b0;
    assign w_rd_byp = 1'b0;
`endif

    always_comb begin
        w_rj_hz = bus.dec_rj_use_i && (w_rj != 5'd0) && (r_sb[w_rj] != '0) && !w_rj_byp;
        w_rk_hz = bus.dec_rk_use_i && (w_rk != 5'd0) && (r_sb[w_rk] != '0) && !w_rk_byp;
        w_rd_hz = bus.dec_rd_use_i && (w_rd != 5'd0) && (r_sb[w_rd] != '0) && !w_rd_byp;
        w_hazard = w_rj_hz || w_rk_hz || w_rd_hz;
    end

    assign w_ready_go = !w_hazard;
    assign w_allowin  = !r_id_valid || (w_ready_go && bus.ex_allowin_i);
    assign w_issue    = r_id_valid && w_ready_go && bus.ex_allowin_i && !bus.flush_i;
    assign w_load     = w_allowin && bus.if_valid_i;

    always_comb begin
        w_id_valid_d = r_id_valid;
        if (bus.flush_i) begin
            w_id_valid_d = 1'b0;
        end else if (w_allowin) begin
            w_id_valid_d = bus.if_valid_i;
        end
    end

    // Simultaneous inc and dec cancel; a lone step saturates instead of wrapping.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            w_sb_d[i] = r_sb[i];
            if (w_inc[i] && !w_dec[i] && (r_sb[i] != SbMax)) begin
                w_sb_d[i] = r_sb[i] + SbOne;
            end else if (w_dec[i] && !w_inc[i] && (r_sb[i] != '0)) begin
                w_sb_d[i] = r_sb[i] - SbOne;
            end
        end
        w_sb_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_id_valid <= 1'b0;
            r_inst     <= 32'h0;
            r_pc       <= 32'h0;
            for (int i = 0; i < 32; i++) begin
                r_sb[i] <= '0;
            end
        end else begin
            r_id_valid <= w_id_valid_d;
            if (w_load) begin
                r_inst <= bus.if_inst_i;
                r_pc   <= bus.if_pc_i;
            end
            for (int i = 0; i < 32; i++) begin
                r_sb[i] <= w_sb_d[i];
            end
        end
    end

    assign bus.id_allowin_o     = w_allowin;
    assign bus.id_to_ex_valid_o = r_id_valid && w_ready_go && !bus.flush_i;
    assign bus.stall_o          = r_id_valid && w_hazard;
    assign bus.dec_inst_o       = r_inst;
    assign bus.id_pc_o          = r_pc;

    // Overflow and underflow mean the pipeline broke the one-write-per-stage protocol.
    for (genvar g = 1; g < 32; g++) begin : g_sb_chk
        a_sb_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
            !(w_inc[g] && !w_dec[g] && (r_sb[g] == SbMax)));
        a_sb_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
            !(w_dec[g] && !w_inc[g] && (r_sb[g] == '0)));
    end
endmodule

// File: doc/id_issue_ctrl.md
# id_issue_ctrl

Decode-stage issue controller for the LA32R pipeline.
- Holds the one instruction in ID and drives the opcode/register decoder with it.
- Tracks in-flight register writes in a per-register scoreboard and stalls the instruction on read-after-write hazards.
- Runs the valid/allowin handshake between IF, ID and EX.
- Sits between the IF/ID pipeline boundary and the ID/EX register; it is the only block that decides when ID advances.

## Interface
Parameters:
- SB_CNT_W, 2: width of each scoreboard counter. Allows up to 3 pending writes per register (EX, MEM, WB).

Ports (name, direction, width, meaning):
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: reset, synchronous, active-low.
- if_valid_i, in, 1: IF presents an instruction.
- if_inst_i, in, 32: instruction word from IF.
- if_pc_i, in, 32: PC of that instruction.
- id_allowin_o, out, 1: ID accepts from IF this cycle.
- flush_i, in, 1: kill the instruction held in ID (branch redirect or exception).
- dec_inst_o, out, 32: held instruction, fed to the decoder.
- dec_rj_use_i, dec_rk_use_i, dec_rd_use_i, in, 1 each: decoder says rj / rk / rd is read as a source.
- dec_we_i, in, 1: decoder says the instruction writes a GPR.
- dec_wdest_i, in, 5: GPR written (rd, or r1 for BL).
- ex_allowin_i, in, 1: EX accepts this cycle.
- id_to_ex_valid_o, out, 1: ID presents a hazard-free instruction to EX.
- id_pc_o, out, 32: PC of the held instruction.
- wb_valid_i, in, 1: WB retires an instruction this cycle.
- wb_we_i, in, 1: the retiring instruction writes a GPR.
- wb_dest_i, in, 5: GPR written by the retiring instruction.
- stall_o, out, 1: ID holds a valid instruction that is blocked by a hazard.

## Operation
- State: id_valid, the instruction register, the PC register, and 32 counters sb[0..31] of width SB_CNT_W.
- Source registers come from the held instruction: rj = inst[9:5], rk = inst[14:10], rd = inst[4:0].
- hazard = (rj_use && sb[rj]≠0) || (rk_use && sb[rk]≠0) || (rd_use && sb[rd]≠0).
- A source index of 0 never produces a hazard.
- ready_go = !hazard.
- id_allowin_o = !id_valid || (ready_go && ex_allowin_i).
- id_to_ex_valid_o = id_valid && ready_go && !flush_i.
- stall_o = id_valid && hazard.
- issue = id_valid && ready_go && ex_allowin_i && !flush_i.
- The instruction and PC registers load when id_allowin_o && if_valid_i.
- Next id_valid:
  - 0 if flush_i.
  - otherwise if_valid_i, if id_allowin_o.
  - otherwise unchanged.
- Scoreboard update per register r, in the same cycle:
  - inc(r) = issue && dec_we_i && dec_wdest_i==r && r≠0.
  - dec(r) = wb_valid_i && wb_we_i && wb_dest_i==r && r≠0.
  - inc and dec together: no change. inc alone: +1. dec alone: −1.
- sb[0] is always 0.
- Overflow (sb=max with inc) and underflow (sb=0 with dec) are protocol errors. The counter saturates, and a simulation-only assertion fires.
- flush_i does not touch the scoreboard: instructions older than the flush still write back. A flushed ID instruction was never issued, so it never incremented the scoreboard.

## Timing
- Reset values: id_valid=0, instruction=32'h0, PC=32'h0, all sb=0. As a result id_allowin_o=1, id_to_ex_valid_o=0 and stall_o=0.
- rst_n low during a stall drops the held instruction at the next edge.
- IF→ID latency is 1 cycle: ID holds an accepted instruction from the next cycle on.
- ID→EX is combinational: the same cycle the hazard clears and EX allows in.
- The scoreboard increments at the issue edge and is visible to the next instruction in the following cycle.
  - Back-to-back dependent instructions therefore stall until the producer retires (no forwarding).
- Without the bypass feature below, a WB decrement becomes visible one cycle after wb_valid_i.
- A flush in the same cycle as a hazard clearing: id_to_ex_valid_o=0 and nothing increments.
- A flush together with if_valid_i and id_allowin_o: the incoming instruction is dropped (id_valid becomes 0).

## Configuration
- ID_WB_BYPASS_EN defined:
  - A source counts as hazard-free when sb[src]==1 and a decrement of src by WB is happening in the same cycle.
  - This saves one stall cycle per retiring dependency. The register file must write-first.
- ID_WB_BYPASS_EN undefined: the hazard equation uses only the registered sb values.

## Test plan
- Reset: hold rst_n=0 for 2 cycles → id_allowin_o=1, id_to_ex_valid_o=0, every sb=0.
- Independent stream: addi.w r1,r0,5 then addi.w r2,r0,7 with ex_allowin_i=1 → each issues 1 cycle after IF acceptance; stall_o stays 0; sb[1] and sb[2] each go to 1.
- RAW stall: add.w r3,r1,r1 right after a write to r1 → stall_o=1 and id_allowin_o=0 until wb_dest_i=1 retires.
  - The instruction issues on the following cycle, or in the retire cycle when ID_WB_BYPASS_EN is set.
- Multiple writers: three writes to r4 issue in sequence → sb[4]=3.
  - Inc and dec of r4 in the same cycle → sb[4] stays 3.
  - A reader of r4 issues only after sb[4]=0.
- r0: an instruction that writes r0, then one that reads r0 → sb[0]=0 and no stall.
- Flush: flush_i=1 while an instruction is stalled → id_valid=0 the next cycle, no scoreboard change, and id_allowin_o=1.
